// File: rtl/ram_simple_dp_sync_be_pipe.sv
// ram_simple_dp_sync_be_pipe: simple dual-port RAM with byte enables, read-valid flag and optional output register
module ram_simple_dp_sync_be_pipe #(
   parameter int DATA_WIDTH  = 64,
   parameter int DEPTH       = 2048,
   parameter int ADDR_WIDTH  = $clog2(DEPTH),
   parameter int OUT_REG     = 0,
   parameter int WRITE_FIRST = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [ADDR_WIDTH-1:0]   write_addr,
   input  logic [DATA_WIDTH-1:0]   din,
   input  logic                    re,
   input  logic [ADDR_WIDTH-1:0]   read_addr,
   output logic [DATA_WIDTH-1:0]   dout,
   output logic                    dout_valid
);
   localparam int NB = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
   logic                  wr_ok;
   logic                  rd_ok;
   logic [DATA_WIDTH-1:0] old_word;
   logic [DATA_WIDTH-1:0] merged;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] d1;
   logic                  v1;
   assign wr_ok = we && ({1'b0, write_addr} < LIMIT);
   assign rd_ok = {1'b0, read_addr} < LIMIT;
   // read word selection: out-of-range reads give zero, write-first collisions see the merged word
   always_comb begin
      old_word = rd_ok ? mem[read_addr] : '0;
      merged   = old_word;
      for (int k = 0; k < NB; k++)
         merged[8*k +: 8] = be[k] ? din[8*k +: 8] : old_word[8*k +: 8];
      rd_word  = (WRITE_FIRST != 0 && wr_ok && write_addr == read_addr) ? merged : old_word;
   end
   // byte-masked write; contents survive reset and out-of-range writes are dropped
   always_ff @(posedge clk) begin
      if (!rst && wr_ok)
         for (int k = 0; k < NB; k++)
            if (be[k]) mem[write_addr][8*k +: 8] <= din[8*k +: 8];
   end
   // first read stage: capture word and valid on an accepted read, hold data otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         d1 <= '0;
      end else begin
         v1 <= re;
         if (re) d1 <= rd_word;
      end
   end
   generate
      if (OUT_REG != 0) begin : g_out
         logic [DATA_WIDTH-1:0] d2;
         logic                  v2;
         // optional output stage adds one cycle of latency
         always_ff @(posedge clk) begin
            if (rst) begin
               v2 <= 1'b0;
               d2 <= '0;
            end else begin
               v2 <= v1;
               if (v1) d2 <= d1;
            end
         end
         assign dout       = d2;
         assign dout_valid = v2;
      end else begin : g_direct
         assign dout       = d1;
         assign dout_valid = v1;
      end
   endgenerate
endmodule

// File: tb/tb_ram_simple_dp_sync_be_pipe.sv
// tb_ram_simple_dp_sync_be_pipe: directed and streaming checks on three RAM configurations
module tb_ram_simple_dp_sync_be_pipe;
   logic        clk = 1'b0;
   logic        rst, we, re, we2, re2;
   logic [7:0]  be;
   logic [10:0] wa, ra;
   logic [9:0]  wa2, ra2;
   logic [63:0] din;
   logic [63:0] dout0, dout1, dout2;
   logic        v0, v1, v2;
   logic [63:0] model [2048];
   int          n_cmp = 0;
   int          n_err = 0;
   int          n_acc = 0;
   int          c0 = 0;
   int          c1 = 0;

   always #5 clk = ~clk;

   ram_simple_dp_sync_be_pipe #(.DATA_WIDTH(64), .DEPTH(2048), .OUT_REG(0), .WRITE_FIRST(0)) u0 (
      .clk(clk), .rst(rst), .we(we), .be(be), .write_addr(wa), .din(din),
      .re(re), .read_addr(ra), .dout(dout0), .dout_valid(v0));
   ram_simple_dp_sync_be_pipe #(.DATA_WIDTH(64), .DEPTH(2048), .OUT_REG(1), .WRITE_FIRST(1)) u1 (
      .clk(clk), .rst(rst), .we(we), .be(be), .write_addr(wa), .din(din),
      .re(re), .read_addr(ra), .dout(dout1), .dout_valid(v1));
   ram_simple_dp_sync_be_pipe #(.DATA_WIDTH(64), .DEPTH(1000), .OUT_REG(0), .WRITE_FIRST(0)) u2 (
      .clk(clk), .rst(rst), .we(we2), .be(be), .write_addr(wa2), .din(din),
      .re(re2), .read_addr(ra2), .dout(dout2), .dout_valid(v2));

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic stream(input int wbase, input int rbase);
      logic        p_re = 1'b0;
      logic [63:0] p_exp = '0;
      logic [63:0] e0;
      for (int i = 0; i < 2048; i++) begin
         we  = 1'($urandom_range(0, 1));
         wa  = 11'(wbase + int'($urandom_range(0, 1023)));
         din = {$urandom, $urandom};
         be  = 8'hFF;
         re  = 1'($urandom_range(0, 1));
         ra  = 11'(rbase + int'($urandom_range(0, 1023)));
         e0  = model[ra];
         if (re) n_acc++;
         step;
         if (we) model[wa] = din;
         chk("s_v0", 64'(v0), 64'(re));
         if (re) chk("s_d0", dout0, e0);
         chk("s_v1", 64'(v1), 64'(p_re));
         if (p_re) chk("s_d1", dout1, p_exp);
         if (v0) c0++;
         if (v1) c1++;
         p_re  = re;
         p_exp = e0;
      end
      we = 1'b0;
      re = 1'b0;
      step;
      chk("f_v0", 64'(v0), 64'd0);
      chk("f_v1", 64'(v1), 64'(p_re));
      if (p_re) chk("f_d1", dout1, p_exp);
      if (v1) c1++;
      step;
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; re = 1'b0; be = '0; wa = '0; ra = '0; din = '0;
      we2 = 1'b0; re2 = 1'b0; wa2 = '0; ra2 = '0;
      for (int i = 0; i < 2048; i++) model[i] = '0;
      step;
      step;
      chk("rst_d0", dout0, 64'd0);
      chk("rst_v0", 64'(v0), 64'd0);
      chk("rst_d1", dout1, 64'd0);
      chk("rst_v1", 64'(v1), 64'd0);
      chk("rst_v2", 64'(v2), 64'd0);
      rst = 1'b0;
      // full write then back-to-back read
      we = 1'b1; be = 8'hFF; wa = 11'd5; din = 64'h0123456789ABCDEF;
      step;
      we = 1'b0; re = 1'b1; ra = 11'd5;
      step;
      chk("w_d0", dout0, 64'h0123456789ABCDEF);
      chk("w_v0", 64'(v0), 64'd1);
      chk("w_v1_early", 64'(v1), 64'd0);
      re = 1'b0;
      step;
      chk("h_v0", 64'(v0), 64'd0);
      chk("h_d0", dout0, 64'h0123456789ABCDEF);
      chk("w_d1", dout1, 64'h0123456789ABCDEF);
      chk("w_v1", 64'(v1), 64'd1);
      step;
      chk("h_v1", 64'(v1), 64'd0);
      // partial write through low byte enables
      we = 1'b1; be = 8'h0F; wa = 11'd5; din = 64'hFFFFFFFFFFFFFFFF;
      step;
      we = 1'b0; re = 1'b1; ra = 11'd5;
      step;
      chk("p_d0", dout0, 64'h01234567FFFFFFFF);
      re = 1'b0;
      step;
      chk("p_d1", dout1, 64'h01234567FFFFFFFF);
      model[5] = 64'h01234567FFFFFFFF;
      // same-address collision
      we = 1'b1; be = 8'hFF; wa = 11'd10; din = 64'hAAAA;
      step;
      re = 1'b1; ra = 11'd10; din = 64'h5555;
      step;
      chk("c_d0", dout0, 64'hAAAA);
      chk("c_v0", 64'(v0), 64'd1);
      we = 1'b0;
      step;
      chk("c2_d0", dout0, 64'h5555);
      chk("c_d1", dout1, 64'h5555);
      re = 1'b0;
      step;
      chk("c2_d1", dout1, 64'h5555);
      // partial collision: write-first sees merged bytes
      we = 1'b1; re = 1'b1; be = 8'h01; din = 64'h12FF;
      step;
      chk("m_d0", dout0, 64'h5555);
      we = 1'b0; re = 1'b0;
      step;
      chk("m_d1", dout1, 64'h55FF);
      chk("m_v0", 64'(v0), 64'd0);
      model[10] = 64'h55FF;
      // reset while a read is in the output pipeline
      we = 1'b1; be = 8'hFF; wa = 11'd3; din = 64'h3333333333333333;
      step;
      we = 1'b0; re = 1'b1; ra = 11'd3;
      step;
      chk("r_d0_pre", dout0, 64'h3333333333333333);
      re = 1'b0; rst = 1'b1;
      step;
      chk("r_v1", 64'(v1), 64'd0);
      chk("r_d1", dout1, 64'd0);
      chk("r_d0", dout0, 64'd0);
      rst = 1'b0;
      step;
      chk("r2_v1", 64'(v1), 64'd0);
      re = 1'b1;
      step;
      re = 1'b0;
      step;
      chk("r3_d1", dout1, 64'h3333333333333333);
      chk("r3_v1", 64'(v1), 64'd1);
      model[3] = 64'h3333333333333333;
      step;
      // streaming against the model, then with ranges swapped
      stream(1024, 0);
      stream(0, 1024);
      chk("cnt0", 64'(c0), 64'(n_acc));
      chk("cnt1", 64'(c1), 64'(n_acc));
      // non-power-of-two depth: out-of-range accesses
      we2 = 1'b1; be = 8'hFF; wa2 = 10'd999; din = 64'h1234;
      step;
      wa2 = 10'd1005; din = 64'hDEAD;
      step;
      we2 = 1'b0; re2 = 1'b1; ra2 = 10'd1005;
      step;
      chk("o_d2", dout2, 64'd0);
      chk("o_v2", 64'(v2), 64'd1);
      ra2 = 10'd999;
      step;
      chk("o_d2_999", dout2, 64'h1234);
      ra2 = 10'd5;
      step;
      chk("o_d2_5", dout2, 64'd0);
      re2 = 1'b0;
      step;
      chk("o_v2_idle", 64'(v2), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
